// File: rtl/iterative_divider_if.sv
// Request/response bundle for the iterative divider, plus the operation-code type it shares
// with its requesters.
package iterative_divider_pkg;
  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } MulDivCode;
endpackage

interface iterative_divider_if #(parameter int DATA_WIDTH = 32);
  logic                            flush;
  logic                            reqValid;
  logic                            reqReady;
  iterative_divider_pkg::MulDivCode mulDivCode;
  logic [DATA_WIDTH-1:0]           op1;
  logic [DATA_WIDTH-1:0]           op2;
  logic                            respValid;
  logic                            respReady;
  logic [DATA_WIDTH-1:0]           result;
  logic                            busy;

  modport master (
    output flush, reqValid, mulDivCode, op1, op2, respReady,
    input  reqReady, respValid, result, busy
  );

  modport slave (
    input  flush, reqValid, mulDivCode, op1, op2, respReady,
    output reqReady, respValid, result, busy
  );
endinterface

// File: rtl/iterative_divider.sv
// Restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIVIDER_EARLY_OUT_EN to let divide-by-zero and signed overflow skip the iteration phase.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  iterative_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  MulDivCode             r_code;
  logic                  r_neg_q, r_neg_r, r_special;
  logic [DATA_WIDTH-1:0] r_quot, r_divisor, r_rem, r_spec_val, r_result;

  function automatic logic [DATA_WIDTH-1:0] f_abs(input logic signed [DATA_WIDTH-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v < 0) ? DATA_WIDTH'(-v) : DATA_WIDTH'(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                          input logic neg);
    return neg ? DATA_WIDTH'(-mag) : mag;
  endfunction

  logic w_accept, w_is_div, w_is_signed, w_legal, w_div0, w_ovf, w_special;
  logic [DATA_WIDTH-1:0] w_spec_val;
  logic signed [DATA_WIDTH-1:0] w_op1_s, w_op2_s;

  assign w_op1_s     = bus.op1;
  assign w_op2_s     = bus.op2;
  assign w_accept    = bus.reqValid && (r_state == IDLE) && !bus.flush;
  assign w_is_div    = (bus.mulDivCode == MULDIV_DIV) || (bus.mulDivCode == MULDIV_DIVU);
  assign w_is_signed = (bus.mulDivCode == MULDIV_DIV) || (bus.mulDivCode == MULDIV_REM);
  assign w_legal     = bus.mulDivCode inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
  assign w_div0      = (bus.op2 == '0);
  assign w_ovf       = w_is_signed && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
  assign w_special   = w_legal && (w_div0 || w_ovf);
  assign w_spec_val  = w_div0 ? (w_is_div ? '1 : bus.op1) : (w_is_div ? MIN_NEG : '0);

  // One restoring step: the shifted partial remainder needs one extra bit before the trial subtract.
  logic [DATA_WIDTH:0]   w_rem_sh, w_diff;
  logic                  w_q_bit, w_last, w_r_is_div, w_r_legal;
  logic [DATA_WIDTH-1:0] w_rem_nxt, w_quot_nxt, w_final;

  assign w_rem_sh   = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_q_bit    = ~w_diff[DATA_WIDTH];
  assign w_rem_nxt  = w_q_bit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
  assign w_quot_nxt = {r_quot[DATA_WIDTH-2:0], w_q_bit};
  assign w_last     = (r_state == CALC) && (r_cnt == '1);
  assign w_r_is_div = (r_code == MULDIV_DIV) || (r_code == MULDIV_DIVU);
  assign w_r_legal  = r_code inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
  assign w_final    = !w_r_legal ? '0 :
                      r_special  ? r_spec_val :
                      w_r_is_div ? f_apply_sign(w_quot_nxt, r_neg_q) :
                                   f_apply_sign(w_rem_nxt, r_neg_r);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.reqReady  = 1'b0;
    bus.respValid = 1'b0;
    bus.result    = '0;
    bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.reqReady = 1'b1;
        if (w_accept) begin
`ifdef DIVIDER_EARLY_OUT_EN
          w_state_nxt = w_special ? DONE : CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC: if (r_cnt == '1) w_state_nxt = DONE;
      DONE: begin
        bus.respValid = 1'b1;
        bus.result    = r_result;
        if (bus.respReady) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) w_state_nxt = IDLE;
  end

  // Accept latches magnitudes and sign flags; CALC shifts one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_code     <= MULDIV_MUL;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_spec_val <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_code     <= bus.mulDivCode;
      r_neg_q    <= w_is_signed && (bus.op1[DATA_WIDTH-1] ^ bus.op2[DATA_WIDTH-1]);
      r_neg_r    <= w_is_signed && bus.op1[DATA_WIDTH-1];
      r_special  <= w_special;
      r_quot     <= f_abs(w_op1_s, w_is_signed);
      r_divisor  <= f_abs(w_op2_s, w_is_signed);
      r_rem      <= '0;
      r_spec_val <= w_spec_val;
      r_result   <= w_spec_val;
    end else if (r_state == CALC) begin
      r_cnt  <= r_cnt + 1'b1;
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      if (w_last) r_result <= w_final;
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed corner cases, random operations, flush and reset aborts.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iterative_divider_if #(.DATA_WIDTH(32)) bus ();

  iterative_divider #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] lat_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input MulDivCode c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (c)
      MULDIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REMU: return (b == 0) ? a : a % b;
      MULDIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      MULDIV_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:     return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_lat(input MulDivCode c, input logic [31:0] a, input logic [31:0] b);
    logic legal, sgn, special;
    legal   = c inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
    sgn     = (c == MULDIV_DIV) || (c == MULDIV_REM);
    special = legal && ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (EARLY && special) ? 32'd0 : 32'd32;
  endfunction

  task automatic drive_req(input MulDivCode c, input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    while (!bus.reqReady && t < 60) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 60) chk("req_ready_timeout", 32'(bus.reqReady), 32'd1);
    bus.reqValid   = 1'b1;
    bus.mulDivCode = c;
    bus.op1        = a;
    bus.op2        = b;
    @(posedge clk); #1;
    bus.reqValid   = 1'b0;
  endtask

  task automatic run_op(input MulDivCode c, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] e, el;
    exp_q.push_back(model(c, a, b));
    lat_q.push_back(model_lat(c, a, b));
    drive_req(c, a, b);
    lat = 0;
    while (!bus.respValid && lat < 60) begin
      if (lat == 5) chk("result_zero_while_busy", bus.result, 32'h0);
      @(posedge clk); #1; lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    if (lat >= 60) begin
      chk("resp_timeout", 32'(bus.respValid), 32'd1);
      return;
    end
    chk($sformatf("res_%s_%h_%h", c.name(), a, b), bus.result, e);
    chk("latency", 32'(lat), el);
    chk("req_ready_in_done", 32'(bus.reqReady), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.respValid), 32'd1);
      chk("hold_result", bus.result, e);
      chk("hold_req_ready", 32'(bus.reqReady), 32'd0);
    end
    bus.respReady = 1'b1;
    @(posedge clk); #1;
    bus.respReady = 1'b0;
    chk("idle_after_resp", 32'(bus.reqReady), 32'd1);
    chk("valid_drop", 32'(bus.respValid), 32'd0);
    chk("result_zero_idle", bus.result, 32'h0);
  endtask

  task automatic watch_no_resp(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.respValid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.reqValid   = 1'b0;
    bus.respReady  = 1'b0;
    bus.mulDivCode = MULDIV_DIVU;
    bus.op1        = '0;
    bus.op2        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.reqReady), 32'd1);
    chk("rst_resp_valid", 32'(bus.respValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    rst = 1'b0;

    run_op(MULDIV_DIVU, 32'd100, 32'd7, 0);
    run_op(MULDIV_REMU, 32'd100, 32'd7, 0);
    run_op(MULDIV_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    run_op(MULDIV_REM,  32'hFFFF_FFF9, 32'd2, 0);
    run_op(MULDIV_DIV,  32'd5, 32'd0, 0);
    run_op(MULDIV_REM,  32'd5, 32'd0, 0);
    run_op(MULDIV_DIVU, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(MULDIV_REM,  32'hFFFF_FFFB, 32'd0, 0);
    run_op(MULDIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MULDIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MULDIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MULDIV_DIV,  32'd7, 32'hFFFF_FFFE, 0);
    run_op(MULDIV_MUL,  32'd6, 32'd3, 0);
    run_op(MULDIV_MULHU, 32'd9, 32'd0, 0);
    run_op(MULDIV_DIVU, 32'hDEAD_BEEF, 32'd1234, 10);

    // Flush at CALC cycle 10 while a new request is offered.
    drive_req(MULDIV_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.flush      = 1'b1;
    bus.reqValid   = 1'b1;
    bus.mulDivCode = MULDIV_DIVU;
    bus.op1        = 32'd50;
    bus.op2        = 32'd5;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.reqValid = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_req_ready", 32'(bus.reqReady), 32'd1);
    chk("flush_resp_valid", 32'(bus.respValid), 32'd0);
    watch_no_resp("flush_no_resp", 40);
    run_op(MULDIV_REMU, 32'd50, 32'd6, 0);

    // Reset in the middle of an operation.
    drive_req(MULDIV_DIV, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_req_ready", 32'(bus.reqReady), 32'd1);
    watch_no_resp("midrst_no_resp", 40);

    for (int k = 0; k < 20; k++) begin
      MulDivCode c;
      logic [31:0] a, b;
      c = MulDivCode'($urandom_range(7));
      a = $urandom;
      case ($urandom_range(3))
        0:       b = 32'd0;
        1:       b = $urandom_range(255);
        2:       b = 32'hFFFF_FF00 | 32'($urandom_range(255));
        default: b = $urandom;
      endcase
      if (k % 4 == 1) c = MulDivCode'(3'd4 + 3'($urandom_range(3)));
      run_op(c, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: IterativeDivider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  pipeline flush; aborts any operation.
REQ-005 SHALL have port reqValid  input  1  request present.
REQ-006 SHALL have port reqReady  output  1  unit can accept a request.
REQ-007 SHALL have port mulDivCode  input  MulDivCode  operation; only MULDIV_DIV/DIVU/REM/REMU legal.
REQ-008 SHALL have ports op1, op2  input  32 each  dividend, divisor.
REQ-009 SHALL have port respValid  output  1  result present.
REQ-010 SHALL have port respReady  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  32  quotient or remainder.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE (pipeline stall source).

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; reqReady=1 only in IDLE.
REQ-014 Accept = reqValid&&reqReady at edge T; SHALL latch code, operand magnitudes and result-sign flags, then go to CALC.
REQ-015 Signed ops (DIV/REM) SHALL divide absolute values; quotient negated iff op1/op2 signs differ; remainder takes sign of op1.
REQ-016 CALC SHALL run restoring division, one quotient bit per cycle, MSB first, 32 cycles via 5-bit counter; 33-bit partial remainder to avoid overflow.
REQ-017 After the 32nd CALC cycle SHALL apply sign fix-up and enter DONE; respValid rises at cycle T+33.
REQ-018 DONE SHALL hold respValid and result stable until respValid&&respReady, then return to IDLE; no new request accepted in the same cycle.
REQ-019 Divisor zero SHALL yield quotient 0xFFFFFFFF (DIV, DIVU) and remainder op1 (REM, REMU).
REQ-020 DIV with op1=0x80000000, op2=0xFFFFFFFF SHALL yield 0x80000000; REM same operands SHALL yield 0.
REQ-021 Illegal mulDivCode on accept SHALL complete with result 0 using normal latency.
REQ-022 flush in any state SHALL return to IDLE next cycle with respValid=0, result discarded; flush has priority over reqValid and respReady in the same cycle.
REQ-023 result SHALL be 0 whenever respValid=0.

Reset
REQ-024 On rst, next edge: state IDLE, reqReady=1, respValid=0, busy=0, result=0, counter and datapath registers 0.
REQ-025 rst mid-CALC or in DONE SHALL abort the operation; no response ever issued for it; rst has priority over flush.

Configuration
REQ-026 Macro DIVIDER_EARLY_OUT_EN defined: divisor-zero and signed-overflow cases (REQ-019/020) SHALL bypass CALC, entering DONE directly; respValid at T+1.
REQ-027 Macro undefined: those cases SHALL take the full 33-cycle latency with identical results via special-case output mux.

Verification
REQ-028 DIVU op1=100, op2=7 -> respValid at T+33, result 14; REMU same -> 2.
REQ-029 DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1).
REQ-030 DIV op2=0, op1=5 -> 0xFFFFFFFF; REM -> 5; latency T+1 with DIVIDER_EARLY_OUT_EN, T+33 without.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 respReady held low 10 cycles in DONE -> result stable, reqReady=0; then respReady=1 -> IDLE next cycle.
REQ-033 flush at CALC cycle 10 with reqValid=1 -> IDLE, no respValid, request not accepted; next request completes normally.
